// File: rtl/preemp_ctrl_pkg.sv
// Shared speech-frontend definitions: frame-buffer geometry, sample widths
// and the pre-emphasis sequencer state encoding.
package preemp_ctrl_pkg;

  localparam int unsigned BUF_DEPTH = 512;
  localparam int unsigned BUF_AW    = 9;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned PE_W      = 17;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    ISSUE = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } pe_state_e;

endpackage

// File: rtl/preemp_ctrl_tag_pipe.sv
// Delay line marking which issue cycles expect a pe_out capture PE_LAT
// cycles later; flush drops every in-flight tag.
module pe_tag_pipe #(
  parameter int unsigned PE_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic tag_in,
  output logic tag_out_c,
  output logic pending_c
);

  logic [PE_LAT-1:0] tags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tags <= '0;
    end else if (flush) begin
      tags <= '0;
    end else begin
      tags <= PE_LAT'({tags, tag_in});
    end
  end

  assign tag_out_c = tags[PE_LAT-1];
  assign pending_c = |tags;

endmodule

// File: rtl/preemp_ctrl.sv
// Sequences samples through an external pre-emphasis stage and writes the
// results into a circular frame buffer, flagging analysis-frame boundaries.
module preemp_ctrl
  import preemp_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned FRAME_SHIFT = 128,
  parameter int unsigned PE_LAT      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  input  logic                utt_start,
  input  logic                utt_end,
  output logic [SAMPLE_W-1:0] pe_in,
  output logic                pe_en,
  output logic                pe_newspeech,
  input  logic [PE_W-1:0]     pe_out,
  output logic                wr_en,
  output logic [BUF_AW-1:0]   wr_addr,
  output logic [PE_W-1:0]     wr_data,
  output logic                frame_done,
  output logic [BUF_AW-1:0]   frame_base,
  output logic                utt_done,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN) + 1;

  pe_state_e         state_q, state_d;
  logic              end_pend_q, end_pend_d;
  logic              first_q;
  logic              in_ready_d, busy_d, pe_en_d, pe_newspeech_d, utt_done_d;
  logic              accept_c, abort_c, capture_c, hit_c;
  logic              tag_in_c, tag_out_c, pending_c;
  logic [BUF_AW-1:0] wr_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              seen_q;

  // Delimiters win over a coincident handshake; such a sample is dropped.
  assign accept_c  = in_valid & in_ready & ~utt_start & ~utt_end;
  assign abort_c   = utt_start & (state_q != IDLE);
  assign tag_in_c  = pe_en & ~pe_newspeech;
  assign capture_c = tag_out_c & ~abort_c;
  assign hit_c     = (cnt_q == (seen_q ? CNT_W'(FRAME_SHIFT - 1) : CNT_W'(FRAME_LEN - 1)));

  pe_tag_pipe #(.PE_LAT(PE_LAT)) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort_c),
    .tag_in    (tag_in_c),
    .tag_out_c (tag_out_c),
    .pending_c (pending_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (utt_start) state_d = ARMED;
      ARMED, HOLD: begin
        if (utt_start)                  state_d = ARMED;
        else if (utt_end || end_pend_q) state_d = DRAIN;
        else if (accept_c)              state_d = ISSUE;
      end
      ISSUE:       state_d = utt_start ? ARMED : HOLD;
      DRAIN: begin
        if (utt_start)       state_d = ARMED;
        else if (!pending_c) state_d = IDLE;
      end
      default:     state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so the registered copies line up with state_q.
  always_comb begin
    end_pend_d     = (state_q == ISSUE) & utt_end & ~utt_start;
    in_ready_d     = (state_d == ARMED) | ((state_d == HOLD) & ~end_pend_d);
    busy_d         = (state_d != IDLE);
    pe_en_d        = (state_d == ISSUE);
    pe_newspeech_d = (state_d == ISSUE) & first_q;
    utt_done_d     = (state_q == DRAIN) & (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      pe_en        <= 1'b0;
      pe_newspeech <= 1'b0;
      pe_in        <= '0;
      utt_done     <= 1'b0;
      end_pend_q   <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      in_ready     <= in_ready_d;
      busy         <= busy_d;
      pe_en        <= pe_en_d;
      pe_newspeech <= pe_newspeech_d;
      utt_done     <= utt_done_d;
      end_pend_q   <= end_pend_d;
      if (utt_start)     first_q <= 1'b1;
      else if (accept_c) first_q <= 1'b0;
      if (accept_c)      pe_in   <= in_data;
    end
  end

  // Capture, circular write pointer and frame-boundary counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_ptr     <= '0;
      frame_done <= 1'b0;
      frame_base <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
    end else begin
      wr_en      <= capture_c;
      frame_done <= capture_c & hit_c;
      if (capture_c) begin
        wr_addr <= wr_ptr;
        wr_data <= pe_out;
        wr_ptr  <= wr_ptr + BUF_AW'(1);
      end
      if (capture_c && hit_c) frame_base <= wr_ptr - BUF_AW'(FRAME_LEN - 1);
      if (utt_start) begin
        cnt_q  <= '0;
        seen_q <= 1'b0;
      end else if (capture_c) begin
        cnt_q <= hit_c ? '0 : cnt_q + CNT_W'(1);
        if (hit_c) seen_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_preemp_ctrl.sv
// Scoreboard bench for preemp_ctrl: expected buffer writes are queued as
// samples are issued and matched against observed wr_en events.
module tb_preemp_ctrl;

  localparam int unsigned FRAME_LEN   = 256;
  localparam int unsigned FRAME_SHIFT = 128;
  localparam int unsigned PE_LAT      = 2;

  typedef struct packed {
    logic [8:0]  addr;
    logic [16:0] data;
    logic        fd;
    logic [8:0]  base;
  } wr_ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        utt_start = 1'b0;
  logic        utt_end = 1'b0;
  logic        in_ready, pe_en, pe_newspeech, wr_en, frame_done, utt_done, busy;
  logic [15:0] pe_in;
  logic [16:0] pe_out, wr_data;
  logic [8:0]  wr_addr, frame_base;

  wr_ev_t exp_q[$];
  wr_ev_t obs_q[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     last_wr_cyc = 0;
  int     utt_done_cyc = 0;
  int     utt_done_cnt = 0;
  int     stray_fd = 0;
  int     ptr_m = 0;
  int     cnt_m = 0;
  bit     first_m = 1'b1;

  preemp_ctrl #(.FRAME_LEN(FRAME_LEN), .FRAME_SHIFT(FRAME_SHIFT), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .utt_start(utt_start), .utt_end(utt_end), .pe_in(pe_in), .pe_en(pe_en),
    .pe_newspeech(pe_newspeech), .pe_out(pe_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .frame_base(frame_base),
    .utt_done(utt_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] pe_fn(input logic [15:0] x);
    return {x[15], x} + 17'h00123;
  endfunction

  // Stand-in pre-emphasis stage: result valid exactly PE_LAT cycles after pe_en.
  logic [16:0] pe_pipe [PE_LAT];
  always @(posedge clk) begin
    pe_pipe[0] <= pe_en ? pe_fn(pe_in) : 17'h1ffff;
    for (int i = 1; i < PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
  end
  assign pe_out = pe_pipe[PE_LAT-1];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clk_step();
    wr_ev_t ev;
    @(negedge clk);
    cyc++;
    if (wr_en === 1'b1) begin
      ev.addr = wr_addr;
      ev.data = wr_data;
      ev.fd   = frame_done;
      ev.base = (frame_done === 1'b1) ? frame_base : 9'd0;
      obs_q.push_back(ev);
      last_wr_cyc = cyc;
    end else if (frame_done !== 1'b0) begin
      stray_fd++;
    end
    if (utt_done === 1'b1) begin
      utt_done_cnt++;
      utt_done_cyc = cyc;
    end
  endtask

  task automatic model_reset();
    ptr_m = 0;
    cnt_m = 0;
    first_m = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; utt_start = 1'b0; utt_end = 1'b0;
    reset = 1'b0;
    repeat (2) clk_step();
    reset = 1'b1;
    clk_step();
    model_reset();
  endtask

  task automatic start_utt();
    utt_start = 1'b1;
    clk_step();
    utt_start = 1'b0;
    first_m = 1'b1;
    cnt_m = 0;
    utt_done_cnt = 0;
  endtask

  task automatic drive_sample(input logic [15:0] d, input bit capt);
    wr_ev_t e;
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin clk_step(); n++; end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL in_ready_wait: in_ready %b, required 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_data = d;
    clk_step();
    in_valid = 1'b0;
    tests++;
    if ({pe_en, pe_newspeech, pe_in} !== {1'b1, first_m, d}) begin
      fails++;
      $display("FAIL issue: pe_en/pe_newspeech/pe_in %b/%b/%h, required 1/%b/%h",
               pe_en, pe_newspeech, pe_in, first_m, d);
    end
    if (capt && !first_m) begin
      cnt_m++;
      e.addr = 9'(ptr_m);
      e.data = pe_fn(d);
      e.fd   = (cnt_m == FRAME_LEN) ||
               (cnt_m > FRAME_LEN && ((cnt_m - FRAME_LEN) % FRAME_SHIFT) == 0);
      e.base = e.fd ? 9'((ptr_m + 512 - FRAME_LEN + 1) % 512) : 9'd0;
      exp_q.push_back(e);
      ptr_m = (ptr_m + 1) % 512;
    end
    first_m = 1'b0;
  endtask

  task automatic end_utt();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin clk_step(); n++; end
    utt_end = 1'b1;
    clk_step();
    utt_end = 1'b0;
    n = 0;
    while (utt_done_cnt == 0 && n < 50) begin clk_step(); n++; end
    repeat (3) clk_step();
    tests++;
    if (utt_done_cnt !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL utt_done: pulses %0d busy %b, required 1 and 0", utt_done_cnt, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) clk_step();
    tests++;
    if ({in_ready, pe_in, pe_en, pe_newspeech, wr_en, wr_addr, wr_data, frame_done,
         frame_base, utt_done, busy} !== 58'd0) begin
      fails++;
      $display("FAIL reset_outputs: nonzero output during reset, required all 0");
    end
    reset = 1'b1;
    repeat (2) clk_step();
    tests++;
    if ({in_ready, pe_en, wr_en, frame_done, utt_done, busy} !== 6'd0) begin
      fails++;
      $display("FAIL idle_outputs: %b, required 000000",
               {in_ready, pe_en, wr_en, frame_done, utt_done, busy});
    end
    model_reset();
  endtask

  task automatic test_basic();
    wr_ev_t e, o;
    start_utt();
    drive_sample(16'h0100, 1'b1);
    drive_sample(16'h0200, 1'b1);
    drive_sample(16'h0300, 1'b1);
    end_utt();
    tests++;
    if (obs_q.size() != 2 || obs_q[0].addr !== 9'd0 || obs_q[1].addr !== 9'd1) begin
      fails++;
      $display("FAIL basic_count: %0d writes, required 2 at addr 0 and 1", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL basic_wr: missing write, required addr %0d data %h", e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL basic_wr: addr/data/fd/base %0d/%h/%b/%0d, required %0d/%h/%b/%0d",
                   o.addr, o.data, o.fd, o.base, e.addr, e.data, e.fd, e.base);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL basic_extra: %0d unexpected writes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_frames();
    wr_ev_t e, o;
    int nfd = 0;
    logic [8:0] bases [3];
    apply_reset();
    start_utt();
    for (int i = 0; i < 513; i++) drive_sample(16'(i * 37), 1'b1);
    end_utt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL frames_wr: missing write, required addr %0d data %h", e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.fd === 1'b1) begin
          if (nfd < 3) bases[nfd] = o.base;
          nfd++;
        end
        if (o !== e) begin
          fails++;
          $display("FAIL frames_wr: addr/data/fd/base %0d/%h/%b/%0d, required %0d/%h/%b/%0d",
                   o.addr, o.data, o.fd, o.base, e.addr, e.data, e.fd, e.base);
        end
      end
    end
    tests++;
    if (nfd != 3 || bases[0] !== 9'd0 || bases[1] !== 9'd128 || bases[2] !== 9'd256) begin
      fails++;
      $display("FAIL frames_count: %0d frames, required 3 with bases 0/128/256", nfd);
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL frames_extra: %0d unexpected writes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_wrap();
    wr_ev_t e, o;
    logic [8:0] prev_addr = 9'd0;
    logic [8:0] last_base = 9'd0;
    bit saw_wrap = 1'b0;
    start_utt();
    for (int i = 0; i < 501; i++) drive_sample(16'(16'h4000 + i), 1'b1);
    end_utt();
    start_utt();
    for (int i = 0; i < 257; i++) drive_sample(16'(16'h8000 + i * 3), 1'b1);
    end_utt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL wrap_wr: missing write, required addr %0d data %h", e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (prev_addr == 9'd511 && o.addr == 9'd0) saw_wrap = 1'b1;
        prev_addr = o.addr;
        if (o.fd === 1'b1) last_base = o.base;
        if (o !== e) begin
          fails++;
          $display("FAIL wrap_wr: addr/data/fd/base %0d/%h/%b/%0d, required %0d/%h/%b/%0d",
                   o.addr, o.data, o.fd, o.base, e.addr, e.data, e.fd, e.base);
        end
      end
    end
    tests++;
    if (!saw_wrap || last_base !== 9'd500) begin
      fails++;
      $display("FAIL wrap_base: wrap %b last frame_base %0d, required 1 and 500", saw_wrap, last_base);
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_extra: %0d unexpected writes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_end_in_issue();
    wr_ev_t e, o;
    int n = 0;
    start_utt();
    drive_sample(16'h0A00, 1'b1);
    drive_sample(16'h0B00, 1'b1);
    drive_sample(16'h0C00, 1'b1);
    utt_end = 1'b1;
    clk_step();
    utt_end = 1'b0;
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL end_hold: in_ready %b busy %b, required 0 and 1", in_ready, busy);
    end
    while (utt_done_cnt == 0 && n < 50) begin
      clk_step();
      n++;
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL end_ready: in_ready %b after end, required 0", in_ready);
      end
    end
    repeat (3) clk_step();
    tests++;
    if (utt_done_cnt != 1 || utt_done_cyc != last_wr_cyc + 1) begin
      fails++;
      $display("FAIL end_done: pulses %0d at cycle %0d, required 1 at cycle %0d",
               utt_done_cnt, utt_done_cyc, last_wr_cyc + 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL end_wr: missing write, required addr %0d data %h", e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL end_wr: addr/data/fd/base %0d/%h/%b/%0d, required %0d/%h/%b/%0d",
                   o.addr, o.data, o.fd, o.base, e.addr, e.data, e.fd, e.base);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL end_extra: %0d unexpected writes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_abort();
    wr_ev_t e, o;
    int nfd = 0;
    start_utt();
    drive_sample(16'h1000, 1'b1);
    drive_sample(16'h1100, 1'b1);
    drive_sample(16'h1200, 1'b0);
    clk_step();
    start_utt();
    drive_sample(16'h1300, 1'b1);
    for (int i = 0; i < 256; i++) drive_sample(16'(16'h2000 + i * 5), 1'b1);
    end_utt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL abort_wr: missing write, required addr %0d data %h", e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.fd === 1'b1) nfd++;
        if (o !== e) begin
          fails++;
          $display("FAIL abort_wr: addr/data/fd/base %0d/%h/%b/%0d, required %0d/%h/%b/%0d",
                   o.addr, o.data, o.fd, o.base, e.addr, e.data, e.fd, e.base);
        end
      end
    end
    tests++;
    if (nfd != 1 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL abort_extra: %0d frames %0d extra writes, required 1 and 0", nfd, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_hold();
    start_utt();
    drive_sample(16'h3000, 1'b1);
    drive_sample(16'h3100, 1'b0);
    clk_step();
    reset = 1'b0;
    clk_step();
    tests++;
    if ({in_ready, pe_in, pe_en, pe_newspeech, wr_en, wr_addr, wr_data, frame_done,
         frame_base, utt_done, busy} !== 58'd0) begin
      fails++;
      $display("FAIL hold_reset: nonzero output after reset, required all 0");
    end
    clk_step();
    reset = 1'b1;
    model_reset();
    utt_done_cnt = 0;
    in_valid = 1'b1;
    in_data = 16'h3200;
    repeat (6) clk_step();
    in_valid = 1'b0;
    tests++;
    if (obs_q.size() != 0 || in_ready !== 1'b0 || busy !== 1'b0 || utt_done_cnt != 0) begin
      fails++;
      $display("FAIL hold_release: writes %0d in_ready %b busy %b utt_done %0d, required 0/0/0/0",
               obs_q.size(), in_ready, busy, utt_done_cnt);
    end
    start_utt();
    drive_sample(16'h3300, 1'b1);
    drive_sample(16'h3400, 1'b1);
    end_utt();
    tests++;
    if (obs_q.size() != 1 || obs_q[0].addr !== 9'd0 || obs_q[0].data !== pe_fn(16'h3400)) begin
      fails++;
      $display("FAIL hold_restart: %0d writes, required 1 at addr 0 data %h", obs_q.size(), pe_fn(16'h3400));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frames();
    test_wrap();
    test_end_in_issue();
    test_abort();
    test_reset_hold();
    tests++;
    if (stray_fd != 0) begin
      fails++;
      $display("FAIL stray_frame_done: %0d pulses without wr_en, required 0", stray_fd);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/preemp_ctrl.md
PREEMP_CTRL -- requirements
Module: preemp_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, samples per analysis frame (power of two, <= 256).
REQ-002 SHALL have parameter FRAME_SHIFT, default 128, samples between successive frame starts (power of two, <= FRAME_LEN).
REQ-003 SHALL have parameter PE_LAT, default 2, clock cycles from the issue cycle to a valid pe_out.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1, in_data input 16, in_ready output 1: sample stream handshake.
REQ-007 SHALL have ports utt_start input 1, utt_end input 1: single-cycle utterance delimiters.
REQ-008 SHALL have ports pe_in output 16, pe_en output 1, pe_newspeech output 1: pre-emphasis drive.
REQ-009 SHALL have port pe_out  input  17  pre-emphasized result.
REQ-010 SHALL have ports wr_en output 1, wr_addr output 9, wr_data output 17: circular 512-entry frame-buffer write.
REQ-011 SHALL have ports frame_done output 1, frame_base output 9, utt_done output 1, busy output 1.

Function
REQ-012 FSM states SHALL be IDLE, ARMED, ISSUE, HOLD, DRAIN.
REQ-013 IDLE -> ARMED on utt_start; ARMED/HOLD -> ISSUE on in_valid & in_ready; ISSUE -> HOLD unconditionally; HOLD/ARMED -> DRAIN on utt_end; DRAIN -> IDLE once the capture pipeline is empty.
REQ-014 in_ready SHALL be 1 only in ARMED and HOLD; throughput is therefore at most one sample per 2 cycles.
REQ-015 In ISSUE: pe_en=1, pe_in = registered accepted sample; pe_newspeech=1 only for the first sample after utt_start, else 0.
REQ-016 Outside ISSUE: pe_en=0, pe_newspeech=0, pe_in holds its last value.
REQ-017 A PE_LAT-deep tag pipeline SHALL capture pe_out exactly PE_LAT cycles after each ISSUE cycle with pe_newspeech=0; the first sample of an utterance SHALL produce no write.
REQ-018 On each capture: wr_en=1 for one cycle, wr_data=pe_out, wr_addr = write pointer; pointer then increments mod 512.
REQ-019 A per-utterance sample count SHALL count captures; frame_done pulses one cycle with the capture that makes count = FRAME_LEN, then every FRAME_SHIFT captures thereafter.
REQ-020 frame_base SHALL equal (wr_addr of that capture - FRAME_LEN + 1) mod 512, valid while frame_done=1.
REQ-021 utt_end during ISSUE SHALL be latched and honoured on entry to HOLD; the in-flight sample is still captured.
REQ-022 utt_done SHALL pulse one cycle on the DRAIN -> IDLE transition; partial trailing frames raise no frame_done.
REQ-023 utt_start in any non-IDLE state SHALL abort: clear the tag pipeline (no pending write), reset the sample count, keep the write pointer, enter ARMED, and flag the next sample as first.
REQ-024 Simultaneous utt_start and utt_end SHALL give utt_start priority.
REQ-025 busy SHALL be 1 in every state except IDLE.

Reset
REQ-026 On reset low: state IDLE, all outputs 0, write pointer 0, sample count 0, tag pipeline cleared, first-sample flag set.
REQ-027 Reset mid-utterance SHALL discard all in-flight samples with no wr_en, frame_done or utt_done pulse.

Structure
REQ-028 The FSM state encoding, BUF_DEPTH=512 and BUF_AW=9 SHALL live in a shared speech-frontend package.
REQ-029 The tag/capture delay line SHALL be one sub-module, pe_tag_pipe, parameterised by PE_LAT.
REQ-030 preemp_ctrl SHALL instantiate no arithmetic; it only sequences the pre-emphasis stage.

Verification
REQ-031 utt_start, then 3 samples 0x0100/0x0200/0x0300 back-to-back -> pe_newspeech=1 on first ISSUE only; exactly 2 wr_en pulses, at wr_addr 0 and 1.
REQ-032 FRAME_LEN=256, FRAME_SHIFT=128, 513 samples -> frame_done at captures 256, 384 and 512 with frame_base 0, 128, 256.
REQ-033 Write pointer at 500, 20 captures -> wr_addr wraps 511 -> 0; a frame spanning the wrap reports frame_base = (ptr-255) mod 512.
REQ-034 utt_end asserted in an ISSUE cycle -> that sample still written; utt_done exactly one cycle after the final wr_en; in_ready=0 from HOLD onward.
REQ-035 utt_start mid-utterance, with one capture pending -> pending wr_en suppressed, next sample issued with pe_newspeech=1, count restarts at 0.
REQ-036 reset low during HOLD with PE_LAT=2 -> all outputs 0 next cycle; no wr_en after release until new utt_start.
